canvas_scan: RTL

- Upstream feeder of the view-ray generator. On a start pulse it walks every canvas pixel in raster order, one per enabled cycle, and drives the packed canvas location consumed by the view-ray stage.
- Carries a matching address/valid tag through a delay line, so the downstream shading/frame-buffer writer sees each pixel address aligned with the ray the generator produces for it.
- Signals busy and frame completion to the frame controller.

---
 rtl/canvas_scan_pkg.sv | 21 ++
 rtl/canvas_scan_tag_delay.sv | 43 ++++
 rtl/canvas_scan.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/canvas_scan_pkg.sv
// canvas_scan_pkg: scan parameters shared by the canvas scanner and the view-ray stage.
//   COLS_DEF / ROWS_DEF : default canvas size in pixels
//   X_W / Y_W / LOC_W   : field widths of the packed view location {x, y}
//   COL_MID / ROW_MID   : canvas centre, used by the view-ray stage
//   pack_loc()          : builds the packed view location, x at [12:6], y at [5:0]
package canvas_scan_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 60;
    localparam int X_W      = 7;
    localparam int Y_W      = 6;
    localparam int LOC_W    = X_W + Y_W;
    localparam int COL_MID  = COLS_DEF / 2;
    localparam int ROW_MID  = ROWS_DEF / 2;

    function automatic logic [LOC_W-1:0] pack_loc(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/canvas_scan_tag_delay.sv
// canvas_scan_tag_delay: LATENCY-deep shift register of {valid, addr} that keeps each
// pixel address aligned with the ray the free-running view-ray stage produces for it.
//   clk, rst    : clock, asynchronous active-high clear (drops all in-flight tags)
//   i_valid     : tag pushed this cycle is a real pixel (0 = bubble)
//   i_addr      : linear pixel address pushed this cycle
//   o_valid     : valid bit of the oldest entry
//   o_addr      : address of the oldest entry
module canvas_scan_tag_delay #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr
);

    logic              r_valid [LATENCY];
    logic [ADDR_W-1:0] r_addr  [LATENCY];

    // Shifts every cycle; there is no enable because the ray pipeline never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_valid[i] <= 1'b0;
                r_addr[i]  <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_addr[0]  <= i_addr;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_addr[i]  <= r_addr[i-1];
            end
        end
    end

    assign o_valid = r_valid[LATENCY-1];
    assign o_addr  = r_addr[LATENCY-1];

endmodule

// File: rtl/canvas_scan.sv
// canvas_scan: walks every canvas pixel in raster order, one per enabled cycle, driving
// the packed view location and a delayed {valid, addr} tag aligned with the ray output.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : single-cycle pulse, starts a frame when idle (ignored while busy)
//   adv        : advance enable; 0 holds the scan position and pushes a bubble tag
//   view_loc   : {x[6:0], y[5:0]} of the current scan position
//   busy       : high from the cycle after an accepted start through frame_done
//   tag_valid  : the ray now at the view-ray output belongs to a new pixel
//   tag_addr   : linear address y*COLS+x of that pixel
//   frame_done : one-cycle pulse, coincident with the last valid tag
//   dbg_state  : current FSM state (IDLE=0, SCAN=1, DRAIN=2)
module canvas_scan
    import canvas_scan_pkg::*;
#(
    parameter int COLS    = COLS_DEF,
    parameter int ROWS    = ROWS_DEF,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              adv,
    output logic [LOC_W-1:0]  view_loc,
    output logic              busy,
    output logic              tag_valid,
    output logic [ADDR_W-1:0] tag_addr,
    output logic              frame_done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;

    logic w_emit;
    logic w_x_last;
    logic w_y_last;
    logic w_drain_last;
    logic w_accept;

    assign w_emit       = (r_state == ST_SCAN) && adv;
    assign w_x_last     = (r_x == X_W'(COLS - 1));
    assign w_y_last     = (r_y == Y_W'(ROWS - 1));
    assign w_drain_last = (r_state == ST_DRAIN) && (r_cnt == CNT_W'(LATENCY - 1));
    assign w_accept     = (r_state == ST_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        frame_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (w_emit && w_x_last && w_y_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // The last tag leaves the delay line in this same cycle.
                if (w_drain_last) begin
                    w_state_next = ST_IDLE;
                    frame_done   = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Scan position and address. The address is stepped alongside x/y so no
    // multiplier is needed; position and address both freeze on the last pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_x    <= '0;
                r_y    <= '0;
                r_addr <= '0;
                r_cnt  <= '0;
            end else if (w_emit && !(w_x_last && w_y_last)) begin
                r_addr <= r_addr + 1'b1;
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            if (r_state == ST_DRAIN) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign view_loc  = pack_loc(r_x, r_y);
    assign dbg_state = r_state;

    canvas_scan_tag_delay #(
        .LATENCY (LATENCY),
        .ADDR_W  (ADDR_W)
    ) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_emit),
        .i_addr  (r_addr),
        .o_valid (tag_valid),
        .o_addr  (tag_addr)
    );

endmodule
